mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the instruction-fetch requester (IF) and the data requester (MEM stage).
- Produces the i_ready and d_ready handshakes that the pipeline stall logic consumes.
- Data requests have priority, because they belong to the older instruction.
- A starvation limit guarantees that fetch eventually gets through.
- Sits between the pipeline datapath and the memory model.

Parameters:
WORD_SIZE, 16, width of address and data buses
LATENCY, 2, cycles the memory needs a request held before mem_rdata is valid (>=1)
FAIRNESS_LIMIT, 4, consecutive grants to D, while I is pending, after which I is forced (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_readM  in  1  instruction read request, level, held until i_ready
i_address  in  WORD_SIZE  instruction address
i_data  out  WORD_SIZE  fetched instruction, valid while i_ready=1
i_ready  out  1  one-cycle completion pulse for IF
d_readM  in  1  data read request, level
d_writeM  in  1  data write request, level
d_address  in  WORD_SIZE  data address
d_wdata  in  WORD_SIZE  store data
d_rdata  out  WORD_SIZE  load data, valid while d_ready=1
d_ready  out  1  one-cycle completion pulse for MEM (reads and writes)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  WORD_SIZE  memory address
mem_wdata  out  WORD_SIZE  memory write data
mem_rdata  in  WORD_SIZE  memory read data, valid on the last BUSY cycle

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; cnt=0; starve_cnt=0; owner=D.
  - All outputs are 0: i_ready, d_ready, i_data, d_rdata, mem_read, mem_write, mem_address, mem_wdata.
  - An in-flight access is abandoned. No ready pulse follows reset.
- States: IDLE, BUSY, DONE. Encoding is 2 bits.
- IDLE:
  - Request seen on D (d_readM|d_writeM) or I (i_readM) -> latch owner, address, wdata and op; set cnt=LATENCY-1; go to BUSY.
  - Grant rule: D wins, unless I is pending and starve_cnt==FAIRNESS_LIMIT, in which case I wins.
  - d_readM and d_writeM both high -> treated as a write.
  - No request -> stay in IDLE; mem strobes stay 0.
- BUSY:
  - mem_read/mem_write/mem_address/mem_wdata are driven from the latched registers for exactly LATENCY cycles.
  - cnt decrements each cycle.
  - On the cycle cnt==0: capture mem_rdata into i_data or d_rdata (reads only; writes leave d_rdata unchanged), then go to DONE.
- DONE:
  - The owner's ready is high for exactly one cycle; the other ready stays 0. Go to IDLE.
  - Requests are ignored in DONE, so the just-served request is never re-issued.
- Latency: request sampled at edge N -> BUSY for cycles N+1..N+LATENCY -> ready at cycle N+LATENCY+1. A back-to-back access starts LATENCY+2 cycles after the previous one.
- starve_cnt, updated on each IDLE grant:
  - Grant to D with I pending -> starve_cnt+1 (saturates at FAIRNESS_LIMIT).
  - Grant to I -> starve_cnt=0.
  - Grant to D with I idle -> starve_cnt=0.
- Request dropped mid-transaction -> the access still completes and ready still pulses. The requester must tolerate this.
- Address or data changing during BUSY has no effect, because the latched values are used.
- i_data/d_rdata hold their last captured value outside of ready cycles.
- Strobes are registered outputs, with no combinational path from the request inputs.

Decomposition:
- WORD_SIZE comes from the shared constants include.
- Add MEMARB_IDLE/BUSY/DONE state codes and MEMARB_OWNER_I/D to the same constants include.
- Single module; no sub-module is warranted. The starvation counter and latency counter are small enough to stay inline.

Test Plan:
1. Reset release, i_readM=1, i_address=0x0010, mem_rdata=0x6000 -> mem_read=1 and mem_address=0x0010 for 2 cycles; i_ready=1 with i_data=0x6000 on cycle 3 after the request; d_ready=0 throughout.
2. i_readM and d_readM rise together, d_address=0x0040 -> D is served first, with d_ready at cycle 3. I is granted in the following IDLE, with i_ready at cycle 7.
3. d_writeM=1, d_address=0x0020, d_wdata=0xBEEF -> mem_write=1 and mem_wdata=0xBEEF for 2 cycles; d_ready pulses; d_rdata unchanged.
4. i_readM and d_readM held continuously for 6 accesses with FAIRNESS_LIMIT=4 -> grant order D,D,D,D,I,D.
5. reset asserted during BUSY of a D read -> outputs 0 immediately; no d_ready ever pulses for that access; the next request is served normally.
6. LATENCY=1 build, i_readM held high for 3 accesses -> i_ready pulses every 3 cycles; no access is duplicated during DONE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and type codes for the IF/MEM memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MEMARB_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    MEMARB_IDLE = 2'd0,
    MEMARB_BUSY = 2'd1,
    MEMARB_DONE = 2'd2
  } memarb_state_e;

  typedef enum logic {
    MEMARB_OWNER_D = 1'b0,
    MEMARB_OWNER_I = 1'b1
  } memarb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and data access,
// giving data priority while a starvation counter eventually forces a fetch through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = MEMARB_WORD_SIZE,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned FAIRNESS_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned SW = $clog2(FAIRNESS_LIMIT + 1);

  memarb_state_e          state_q, state_d;
  memarb_owner_e          owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [WORD_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0]   i_data_q, i_data_d;
  logic [WORD_SIZE-1:0]   d_rdata_q, d_rdata_d;
  logic                   i_ready_q, i_ready_d;
  logic                   d_ready_q, d_ready_d;

  logic d_req;
  logic grant_i;

  assign d_req   = d_readM | d_writeM;
  assign grant_i = i_readM & (~d_req | (starve_q == SW'(FAIRNESS_LIMIT)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MEMARB_IDLE;
      owner_q     <= MEMARB_OWNER_D;
      cnt_q       <= '0;
      starve_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Strobes are registered: asserted on the grant edge and re-armed while cnt
  // is nonzero, so they are high for exactly LATENCY BUSY cycles.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;

    unique case (state_q)
      MEMARB_IDLE: begin
        if (d_req || i_readM) begin
          state_d = MEMARB_BUSY;
          cnt_d   = CW'(LATENCY - 1);
          if (grant_i) begin
            owner_d    = MEMARB_OWNER_I;
            addr_d     = i_address;
            wdata_d    = '0;
            wr_d       = 1'b0;
            mem_read_d = 1'b1;
            starve_d   = '0;
          end else begin
            owner_d     = MEMARB_OWNER_D;
            addr_d      = d_address;
            wdata_d     = d_wdata;
            wr_d        = d_writeM;
            mem_read_d  = ~d_writeM;
            mem_write_d = d_writeM;
            if (!i_readM)
              starve_d = '0;
            else if (starve_q != SW'(FAIRNESS_LIMIT))
              starve_d = starve_q + 1'b1;
          end
        end
      end

      MEMARB_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MEMARB_DONE;
          if (owner_q == MEMARB_OWNER_I) begin
            i_ready_d = 1'b1;
            if (!wr_q) i_data_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d       = cnt_q - 1'b1;
          mem_read_d  = ~wr_q;
          mem_write_d = wr_q;
        end
      end

      MEMARB_DONE: state_d = MEMARB_IDLE;

      default: state_d = MEMARB_IDLE;
    endcase
  end

  assign i_data      = i_data_q;
  assign i_ready     = i_ready_q;
  assign d_rdata     = d_rdata_q;
  assign d_ready     = d_ready_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LATENCY=2 and LATENCY=1 builds).
module tb_mem_arbiter;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  int           tests_run;
  int           tests_failed;

  logic         i_readM, d_readM, d_writeM;
  logic [W-1:0] i_address, d_address, d_wdata, mem_rdata;
  logic [W-1:0] i_data, d_rdata, mem_address, mem_wdata;
  logic         i_ready, d_ready, mem_read, mem_write;

  logic         i1_readM;
  logic [W-1:0] i1_address, mem1_rdata;
  logic [W-1:0] i1_data, d1_rdata, mem1_address, mem1_wdata;
  logic         i1_ready, d1_ready, mem1_read, mem1_write;

  mem_arbiter #(.WORD_SIZE(W), .LATENCY(2), .FAIRNESS_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WORD_SIZE(W), .LATENCY(1), .FAIRNESS_LIMIT(4)) dut1 (
    .clk(clk), .reset(reset),
    .i_readM(i1_readM), .i_address(i1_address), .i_data(i1_data), .i_ready(i1_ready),
    .d_readM(1'b0), .d_writeM(1'b0), .d_address('0), .d_wdata('0),
    .d_rdata(d1_rdata), .d_ready(d1_ready),
    .mem_read(mem1_read), .mem_write(mem1_write), .mem_address(mem1_address),
    .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests_run++;
    if ({i_ready, d_ready, mem_read, mem_write, i_data, d_rdata, mem_address, mem_wdata} !== '0) begin
      $display("FAIL reset_outputs got r=%b%b s=%b%b id=%h dr=%h a=%h wd=%h exp all 0",
               i_ready, d_ready, mem_read, mem_write, i_data, d_rdata, mem_address, mem_wdata);
      tests_failed++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    i_readM = 1'b1; i_address = 16'h0010; mem_rdata = 16'h6000;
    for (int c = 1; c <= 2; c++) begin
      tick();
      tests_run++;
      if ({mem_read, mem_write, mem_address, i_ready, d_ready} !== {1'b1, 1'b0, 16'h0010, 1'b0, 1'b0}) begin
        $display("FAIL fetch_busy%0d got rd=%b wr=%b a=%h ir=%b dr=%b exp rd=1 wr=0 a=0010 ir=0 dr=0",
                 c, mem_read, mem_write, mem_address, i_ready, d_ready);
        tests_failed++;
      end
    end
    tick();
    tests_run++;
    if ({i_ready, d_ready, mem_read, i_data} !== {1'b1, 1'b0, 1'b0, 16'h6000}) begin
      $display("FAIL fetch_done got ir=%b dr=%b rd=%b id=%h exp ir=1 dr=0 rd=0 id=6000",
               i_ready, d_ready, mem_read, i_data);
      tests_failed++;
    end
    i_readM = 1'b0;
    mem_rdata = 16'hFFFF;
    tick();
    tests_run++;
    if ({i_ready, i_data} !== {1'b0, 16'h6000}) begin
      $display("FAIL fetch_hold got ir=%b id=%h exp ir=0 id=6000", i_ready, i_data);
      tests_failed++;
    end
  endtask

  task automatic test_priority();
    i_readM = 1'b1; i_address = 16'h0080;
    d_readM = 1'b1; d_address = 16'h0040; mem_rdata = 16'h1234;
    tick();
    tests_run++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0040}) begin
      $display("FAIL prio_dgrant got rd=%b a=%h exp rd=1 a=0040", mem_read, mem_address);
      tests_failed++;
    end
    tick(); tick();
    tests_run++;
    if ({d_ready, i_ready, d_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
      $display("FAIL prio_dready got dr=%b ir=%b d=%h exp dr=1 ir=0 d=1234", d_ready, i_ready, d_rdata);
      tests_failed++;
    end
    d_readM = 1'b0; mem_rdata = 16'h5678;
    tick(); tick();
    tests_run++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0080}) begin
      $display("FAIL prio_igrant got rd=%b a=%h exp rd=1 a=0080", mem_read, mem_address);
      tests_failed++;
    end
    tick(); tick();
    tests_run++;
    if ({i_ready, d_ready, i_data} !== {1'b1, 1'b0, 16'h5678}) begin
      $display("FAIL prio_iready got ir=%b dr=%b id=%h exp ir=1 dr=0 id=5678", i_ready, d_ready, i_data);
      tests_failed++;
    end
    i_readM = 1'b0;
    tick();
  endtask

  task automatic test_write();
    d_writeM = 1'b1; d_address = 16'h0020; d_wdata = 16'hBEEF; mem_rdata = 16'h9999;
    tick();
    d_wdata = 16'h1111; d_address = 16'h0099;
    for (int c = 1; c <= 2; c++) begin
      tests_run++;
      if ({mem_write, mem_read, mem_address, mem_wdata} !== {1'b1, 1'b0, 16'h0020, 16'hBEEF}) begin
        $display("FAIL write_busy%0d got wr=%b rd=%b a=%h wd=%h exp wr=1 rd=0 a=0020 wd=BEEF",
                 c, mem_write, mem_read, mem_address, mem_wdata);
        tests_failed++;
      end
      tick();
    end
    tests_run++;
    if ({d_ready, mem_write, d_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
      $display("FAIL write_done got dr=%b wr=%b d=%h exp dr=1 wr=0 d=1234", d_ready, mem_write, d_rdata);
      tests_failed++;
    end
    d_writeM = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    logic exp_i [6];
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    i_readM = 1'b1; i_address = 16'h0100;
    d_readM = 1'b1; d_address = 16'h0200; mem_rdata = 16'h4242;
    for (int k = 0; k < 6; k++) begin
      tick(); tick(); tick();
      tests_run++;
      if ({i_ready, d_ready} !== {exp_i[k], ~exp_i[k]}) begin
        $display("FAIL fair_grant%0d got ir=%b dr=%b exp ir=%b dr=%b", k, i_ready, d_ready, exp_i[k], ~exp_i[k]);
        tests_failed++;
      end
      if (k == 5) begin
        i_readM = 1'b0; d_readM = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    d_readM = 1'b1; d_address = 16'h0030; mem_rdata = 16'h7777;
    tick();
    tests_run++;
    if (mem_read !== 1'b1) begin
      $display("FAIL midrst_busy got rd=%b exp 1", mem_read);
      tests_failed++;
    end
    #2 reset = 1'b1;
    #1;
    d_readM = 1'b0;
    tests_run++;
    if ({i_ready, d_ready, mem_read, mem_write, i_data, d_rdata, mem_address, mem_wdata} !== '0) begin
      $display("FAIL midrst_async got rd=%b a=%h dr=%b d=%h exp all 0", mem_read, mem_address, d_ready, d_rdata);
      tests_failed++;
    end
    #1 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if ({d_ready, mem_read} !== 2'b00) begin
        $display("FAIL midrst_quiet%0d got dr=%b rd=%b exp dr=0 rd=0", c, d_ready, mem_read);
        tests_failed++;
      end
    end
    d_readM = 1'b1; mem_rdata = 16'hA5A5;
    tick(); tick(); tick();
    tests_run++;
    if ({d_ready, d_rdata} !== {1'b1, 16'hA5A5}) begin
      $display("FAIL midrst_next got dr=%b d=%h exp dr=1 d=A5A5", d_ready, d_rdata);
      tests_failed++;
    end
    d_readM = 1'b0;
    tick();
  endtask

  task automatic test_latency1();
    i1_readM = 1'b1; i1_address = 16'h0044; mem1_rdata = 16'h0123;
    for (int k = 1; k <= 9; k++) begin
      tick();
      tests_run++;
      if ({i1_ready, mem1_read} !== {1'((k % 3) == 2), 1'((k % 3) == 1)}) begin
        $display("FAIL lat1_cycle%0d got ir=%b rd=%b exp ir=%b rd=%b", k, i1_ready, mem1_read,
                 (k % 3) == 2, (k % 3) == 1);
        tests_failed++;
      end
    end
    i1_readM = 1'b0;
    tests_run++;
    if (i1_data !== 16'h0123) begin
      $display("FAIL lat1_data got %h exp 0123", i1_data);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset = 1'b1;
    i_readM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    i1_readM = 1'b0; i1_address = '0; mem1_rdata = '0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_write();
    test_fairness();
    test_reset_midflight();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
